pipe_hazard_unit: RTL

Parametrised interlock and forwarding controller for the in-order pipelined CPU. It sits beside the ID stage and tracks every in-flight register writer in a scoreboard shift register of depth WB_LAT. Each cycle it decides whether the ID instruction issues, stalls or is flushed, and which bypass source feeds each operand. It generalises the fixed five-stage pipeline to any writeback latency and adds load-use detection, branch flush and stall accounting.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_hazard_match.sv | 36 +++
 rtl/pipe_hazard_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard unit: bypass select encodings,
// the scoreboard entry payload and the supported size limits.
package pipe_pkg;

    // Deepest supported issue-to-writeback latency.
    localparam int unsigned WB_LAT_MAX = 8;
    // Widest supported register address; narrower addresses are zero-extended.
    localparam int unsigned RD_W       = 8;
    // Width of a scoreboard stage index (covers 0..WB_LAT_MAX).
    localparam int unsigned IDX_W      = 4;

    // Operand bypass source encodings.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    // One in-flight register writer.
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            is_load;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_match.sv
// hazard_match: compares one source register against the live scoreboard
// entries and reports the youngest matching stage.
//   src, used      : source register address and its read enable
//   sb             : scoreboard entries, index 1 = EXE (youngest)
//   hit            : some live entry writes src
//   idx            : stage of the youngest matching entry (0 when no hit)
//   is_load        : that entry is a load
module hazard_match
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic [REG_AW-1:0]      src,
    input  logic                   used,
    input  sb_entry_t [DEPTH:1]    sb,
    output logic                   hit,
    output logic [IDX_W-1:0]       idx,
    output logic                   is_load
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (used && (src != '0) && sb[k].valid && (sb[k].rd == RD_W'(src))) begin
                hit     = 1'b1;
                idx     = IDX_W'(k);
                is_load = sb[k].is_load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: interlock and bypass controller for the ID stage.
// Tracks in-flight register writers in a shift-register scoreboard and decides
// per cycle whether the ID instruction issues, stalls or is flushed, and which
// bypass source feeds each operand.
// Build option: define FORWARD_EN to enable the EXE/MEM bypass network;
// otherwise every in-flight match stalls and the fwd selects are tied to 0.
//   clk, rst                     : clock, async active-high reset
//   id_*                         : decoded ID-stage instruction
//   exe_branch_taken             : branch resolved taken in EXE
//   stall, flush, issue          : pipeline control (combinational)
//   fwd_rs_sel, fwd_rt_sel       : operand sources (combinational)
//   stall_cnt                    : saturating stall-cycle counter
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned WB_LAT = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              exe_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic              issue,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The writer at stage WB_LAT writes the regfile before ID reads it, so it
    // can never cause a hazard and is not held in the scoreboard.
    localparam int unsigned DEPTH = WB_LAT - 1;

    sb_entry_t [DEPTH:1] sb_q;
    sb_entry_t           sb_in;

    logic             rs_hit,  rt_hit;
    logic [IDX_W-1:0] rs_idx,  rt_idx;
    logic             rs_load, rt_load;
    logic             rs_haz,  rt_haz;

    hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_match_rs (
        .src     (id_rs),
        .used    (id_rs_used),
        .sb      (sb_q),
        .hit     (rs_hit),
        .idx     (rs_idx),
        .is_load (rs_load)
    );

    hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_match_rt (
        .src     (id_rt),
        .used    (id_rt_used),
        .sb      (sb_q),
        .hit     (rt_hit),
        .idx     (rt_idx),
        .is_load (rt_load)
    );

`ifdef FORWARD_EN
    // Stall on load-use at EXE or on a match in a stage without a bypass path;
    // otherwise pick the EXE or MEM bypass for a matching operand.
    always_comb begin
        rs_haz     = rs_hit && (((rs_idx == IDX_W'(1)) && rs_load) || (rs_idx >= IDX_W'(3)));
        rt_haz     = rt_hit && (((rt_idx == IDX_W'(1)) && rt_load) || (rt_idx >= IDX_W'(3)));
        fwd_rs_sel = FWD_RF;
        fwd_rt_sel = FWD_RF;
        if (rs_hit && !rs_haz) begin
            fwd_rs_sel = (rs_idx == IDX_W'(1)) ? FWD_EXE : FWD_MEM;
        end
        if (rt_hit && !rt_haz) begin
            fwd_rt_sel = (rt_idx == IDX_W'(1)) ? FWD_EXE : FWD_MEM;
        end
    end
`else
    // No bypass: any in-flight writer of a used source interlocks.
    logic unused_match;
    assign unused_match = ^{rs_idx, rs_load, rt_idx, rt_load};

    always_comb begin
        rs_haz     = rs_hit;
        rt_haz     = rt_hit;
        fwd_rs_sel = FWD_RF;
        fwd_rt_sel = FWD_RF;
    end
`endif

    // Flush wins over stall; a flushed or stalled cycle issues nothing.
    assign flush = exe_branch_taken;
    assign stall = id_valid && (rs_haz || rt_haz) && !flush;
    assign issue = id_valid && !stall && !flush;

    // New EXE entry; writes to register 0 never need tracking.
    assign sb_in = '{valid:   issue && id_rd_we && (id_rd != '0),
                     rd:      RD_W'(id_rd),
                     is_load: id_is_load};

    // Scoreboard shift and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q      <= '0;
            stall_cnt <= '0;
        end else begin
            sb_q[1] <= sb_in;
            for (int k = 2; k <= int'(DEPTH); k++) begin
                sb_q[k] <= sb_q[k-1];
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
